// File: rtl/popcount_accum.sv
// rtl/popcount_accum.sv - pipelined word popcount with per-burst count / nonzero-word / max accumulation
module popcount_accum #(
  parameter  int DATA_W = 512,
  parameter  int ACC_W  = 32,
  localparam int CNT_W  = $clog2(DATA_W + 1),
  localparam int LAT    = 1 + $clog2(DATA_W / 4)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [ACC_W-1:0]  result_count,
  output logic [ACC_W-1:0]  result_nz,
  output logic [CNT_W-1:0]  result_max,
  output logic              result_sat
);

  localparam int G   = DATA_W / 4;
  localparam int NLV = LAT - 1;
  localparam int SW  = ((ACC_W > CNT_W) ? ACC_W : CNT_W) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  // Number of terms alive at tree level k (level 0 = nibble groups).
  function automatic int n_at(input int k);
    return (G + (1 << k) - 1) >> k;
  endfunction

  // All reduction levels share one flat register array; level k starts here.
  function automatic int off_at(input int k);
    int s;
    s = 0;
    for (int j = 1; j < k; j++) s += n_at(j);
    return s;
  endfunction

  localparam int T = off_at(NLV + 1);

  function automatic logic [2:0] pop4(input logic [3:0] n);
    return 3'(n[0]) + 3'(n[1]) + 3'(n[2]) + 3'(n[3]);
  endfunction

  logic [2:0]       grp_d  [G];
  logic [2:0]       grp_q  [G];
  logic [CNT_W-1:0] tree_d [T];
  logic [CNT_W-1:0] tree_q [T];
  logic [CNT_W-1:0] lo, hi;
  logic [NLV:0]     vld_d, vld_q, lst_d, lst_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             cnt_vld_d, cnt_vld_q, cnt_lst_d, cnt_lst_q;
  logic [ACC_W-1:0] acc_cnt_d, acc_cnt_q, acc_nz_d, acc_nz_q;
  logic [CNT_W-1:0] acc_max_d, acc_max_q;
  logic             acc_sat_d, acc_sat_q;
  logic [ACC_W-1:0] res_count_d, res_count_q, res_nz_d, res_nz_q;
  logic [CNT_W-1:0] res_max_d, res_max_q;
  logic             res_sat_d, res_sat_q, res_valid_d, res_valid_q;
  logic             busy_d, busy_q;
  logic [SW-1:0]    sum_cnt, sum_nz;
  logic             sat_cnt, sat_nz, nxt_sat;
  logic [ACC_W-1:0] nxt_cnt, nxt_nz;
  logic [CNT_W-1:0] nxt_max;
  logic             accept;

  assign in_ready     = !rst && !busy_q;
  assign accept       = in_valid && in_ready;
  assign result_valid = res_valid_q;
  assign result_count = res_count_q;
  assign result_nz    = res_nz_q;
  assign result_max   = res_max_q;
  assign result_sat   = res_sat_q;

  always_comb begin
    for (int g = 0; g < G; g++) grp_d[g] = pop4(in_data[4*g +: 4]);
  end

  // Pairwise adder tree; an odd trailing term is added to zero and so passes through.
  always_comb begin
    lo = '0;
    hi = '0;
    for (int t = 0; t < T; t++) tree_d[t] = '0;
    for (int k = 1; k <= NLV; k++) begin
      for (int i = 0; i < (G + 1) / 2; i++) begin
        if (i < n_at(k)) begin
          if (k == 1) begin
            lo = CNT_W'(grp_q[2*i]);
            hi = (2*i + 1 < G) ? CNT_W'(grp_q[2*i + 1]) : '0;
          end else begin
            lo = tree_q[off_at(k - 1) + 2*i];
            hi = (2*i + 1 < n_at(k - 1)) ? tree_q[off_at(k - 1) + 2*i + 1] : '0;
          end
          tree_d[off_at(k) + i] = lo + hi;
        end
      end
    end
  end

  always_comb begin
    vld_d     = {vld_q[NLV-1:0], accept};
    lst_d     = {lst_q[NLV-1:0], accept & in_last};
    cnt_d     = tree_q[T-1];
    cnt_vld_d = vld_q[NLV];
    cnt_lst_d = lst_q[NLV];
  end

  always_comb begin
    sum_cnt = SW'(acc_cnt_q) + SW'(cnt_q);
    sum_nz  = SW'(acc_nz_q) + SW'(cnt_q != '0);
    sat_cnt = sum_cnt > SW'(ACC_MAX);
    sat_nz  = sum_nz > SW'(ACC_MAX);
    nxt_cnt = sat_cnt ? ACC_MAX : sum_cnt[ACC_W-1:0];
    nxt_nz  = sat_nz ? ACC_MAX : sum_nz[ACC_W-1:0];
    nxt_max = (cnt_q > acc_max_q) ? cnt_q : acc_max_q;
    nxt_sat = acc_sat_q | sat_cnt | sat_nz;

    acc_cnt_d   = acc_cnt_q;
    acc_nz_d    = acc_nz_q;
    acc_max_d   = acc_max_q;
    acc_sat_d   = acc_sat_q;
    res_count_d = res_count_q;
    res_nz_d    = res_nz_q;
    res_max_d   = res_max_q;
    res_sat_d   = res_sat_q;
    res_valid_d = res_valid_q & ~result_ready;
    busy_d      = busy_q;

    if (res_valid_q && result_ready) busy_d = 1'b0;
    if (accept && in_last) busy_d = 1'b1;

    if (cnt_vld_q) begin
      if (cnt_lst_q) begin
        res_count_d = nxt_cnt;
        res_nz_d    = nxt_nz;
        res_max_d   = nxt_max;
        res_sat_d   = nxt_sat;
        res_valid_d = 1'b1;
        acc_cnt_d   = '0;
        acc_nz_d    = '0;
        acc_max_d   = '0;
        acc_sat_d   = 1'b0;
      end else begin
        acc_cnt_d = nxt_cnt;
        acc_nz_d  = nxt_nz;
        acc_max_d = nxt_max;
        acc_sat_d = nxt_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    grp_q  <= grp_d;
    tree_q <= tree_d;
    cnt_q  <= cnt_d;
    if (rst) begin
      vld_q       <= '0;
      lst_q       <= '0;
      cnt_vld_q   <= 1'b0;
      cnt_lst_q   <= 1'b0;
      acc_cnt_q   <= '0;
      acc_nz_q    <= '0;
      acc_max_q   <= '0;
      acc_sat_q   <= 1'b0;
      res_count_q <= '0;
      res_nz_q    <= '0;
      res_max_q   <= '0;
      res_sat_q   <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      lst_q       <= lst_d;
      cnt_vld_q   <= cnt_vld_d;
      cnt_lst_q   <= cnt_lst_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_nz_q    <= acc_nz_d;
      acc_max_q   <= acc_max_d;
      acc_sat_q   <= acc_sat_d;
      res_count_q <= res_count_d;
      res_nz_q    <= res_nz_d;
      res_max_q   <= res_max_d;
      res_sat_q   <= res_sat_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_popcount_accum.sv
// tb/tb_popcount_accum.sv - directed and randomized bench for popcount_accum against a burst-level model
module tb_popcount_accum;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int CW = 5;

  logic          clk, rst, in_valid, in_ready, in_last;
  logic          result_valid, result_ready, result_sat;
  logic [DW-1:0] in_data;
  logic [AW-1:0] result_count, result_nz;
  logic [CW-1:0] result_max;
  int            n_cmp = 0;
  int            n_fail = 0;
  int            cyc = 0;

  popcount_accum #(.DATA_W(DW), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .result_valid(result_valid),
    .result_ready(result_ready), .result_count(result_count), .result_nz(result_nz),
    .result_max(result_max), .result_sat(result_sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Burst-level reference: words are collected per burst, totals computed on the last word.
  typedef struct { int due; int c; int n; int m; bit s; } res_t;
  res_t pend[$];
  int   words[$];
  bit   m_busy = 1'b0;
  bit   m_rv = 1'b0;
  bit   m_rs = 1'b0;
  int   m_rc = 0, m_rn = 0, m_rm = 0;

  initial begin
    bit   acc;
    int   tot, nz, mx;
    res_t r;
    forever begin
      @(negedge clk);
      if (pend.size() > 0 && pend[0].due == cyc) begin
        m_rc = pend[0].c; m_rn = pend[0].n; m_rm = pend[0].m; m_rs = pend[0].s;
        m_rv = 1'b1;
        void'(pend.pop_front());
      end
      chk("in_ready",     64'(in_ready),     64'(!rst && !m_busy));
      chk("result_valid", 64'(result_valid), 64'(m_rv));
      chk("result_count", 64'(result_count), 64'(m_rc));
      chk("result_nz",    64'(result_nz),    64'(m_rn));
      chk("result_max",   64'(result_max),   64'(m_rm));
      chk("result_sat",   64'(result_sat),   64'(m_rs));
      if (rst) begin
        pend.delete(); words.delete();
        m_busy = 1'b0; m_rv = 1'b0; m_rs = 1'b0; m_rc = 0; m_rn = 0; m_rm = 0;
      end else begin
        acc = in_valid && !m_busy;
        if (m_rv && result_ready) begin m_rv = 1'b0; m_busy = 1'b0; end
        if (acc) begin
          words.push_back($countones(in_data));
          if (in_last) begin
            tot = 0; nz = 0; mx = 0;
            foreach (words[i]) begin
              tot += words[i];
              if (words[i] != 0) nz++;
              if (words[i] > mx) mx = words[i];
            end
            r.due = cyc + 5;
            r.c = (tot > 255) ? 255 : tot;
            r.n = (nz > 255) ? 255 : nz;
            r.m = mx;
            r.s = (tot > 255) || (nz > 255);
            pend.push_back(r);
            words.delete();
            m_busy = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] w, input logic last);
    int b;
    b = 0;
    in_valid = 1'b1; in_data = w; in_last = last;
    while (!in_ready && b < 200) begin tick(); b++; end
    chk("send_wait", 64'(b < 200), 64'(1));
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic expect_result(input string nm, input int c, input int n, input int m,
                               input bit s, output int lat);
    lat = 0;
    while (!result_valid && lat < 50) begin tick(); lat++; end
    chk({nm, "_valid"}, 64'(result_valid), 64'(1));
    chk({nm, "_count"}, 64'(result_count), 64'(c));
    chk({nm, "_nz"},    64'(result_nz),    64'(n));
    chk({nm, "_max"},   64'(result_max),   64'(m));
    chk({nm, "_sat"},   64'(result_sat),   64'(s));
    result_ready = 1'b1;
    tick();
  endtask

  task automatic drain_random();
    int b;
    bit done;
    b = 0; done = 1'b0;
    while (!done && b < 300) begin
      in_valid     = 1'($urandom_range(0, 1));
      in_data      = 16'($urandom);
      in_last      = 1'($urandom_range(0, 1));
      result_ready = 1'($urandom_range(0, 2) != 0);
      done = result_valid && result_ready;
      tick();
      b++;
    end
    chk("drain_done", 64'(done), 64'(1));
    in_valid = 1'b0; in_last = 1'b0; result_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, b, len, gap;
    logic [DW-1:0] d;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; result_ready = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", 64'(in_ready),     64'(0));
    chk("rst_valid",    64'(result_valid), 64'(0));
    chk("rst_count",    64'(result_count), 64'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));

    send(16'hFFFF, 1'b1);
    chk("single_in_ready_low", 64'(in_ready), 64'(0));
    expect_result("single", 16, 1, 16, 1'b0, lat);
    chk("single_latency", 64'(lat), 64'(4));
    chk("single_after_valid", 64'(result_valid), 64'(0));
    chk("single_after_ready", 64'(in_ready), 64'(1));

    send(16'h0001, 1'b0); send(16'h0000, 1'b0); send(16'h00F0, 1'b1);
    expect_result("b3", 5, 2, 4, 1'b0, lat);

    for (int i = 0; i < 17; i++) send(16'hFFFF, i == 16);
    expect_result("sat", 255, 17, 16, 1'b1, lat);
    send(16'h0003, 1'b1);
    expect_result("post_sat", 2, 1, 2, 1'b0, lat);

    result_ready = 1'b0;
    send(16'h0007, 1'b1);
    b = 0;
    while (!result_valid && b < 50) begin tick(); b++; end
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid",    64'(result_valid), 64'(1));
      chk("hold_count",    64'(result_count), 64'(3));
      chk("hold_max",      64'(result_max),   64'(3));
      chk("hold_in_ready", 64'(in_ready),     64'(0));
      tick();
    end
    result_ready = 1'b1;
    tick();
    chk("hs_valid",    64'(result_valid), 64'(0));
    chk("hs_in_ready", 64'(in_ready),     64'(1));

    send(16'hFFFF, 1'b0); send(16'hFFFF, 1'b0);
    rst = 1'b1;
    tick();
    chk("mid_rst_in_ready", 64'(in_ready),     64'(0));
    chk("mid_rst_valid",    64'(result_valid), 64'(0));
    chk("mid_rst_count",    64'(result_count), 64'(0));
    chk("mid_rst_nz",       64'(result_nz),    64'(0));
    chk("mid_rst_max",      64'(result_max),   64'(0));
    chk("mid_rst_sat",      64'(result_sat),   64'(0));
    rst = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("aborted_no_result", 64'(result_valid), 64'(0));
      tick();
    end
    send(16'h8001, 1'b1);
    expect_result("after_abort", 2, 1, 2, 1'b0, lat);

    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 3; i++) begin
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin in_valid = 1'b0; in_data = 16'($urandom); tick(); end
        send(16'h0F0F, i == 2);
      end
      expect_result("gaps", 24, 3, 8, 1'b0, lat);
    end

    for (int bst = 0; bst < 40; bst++) begin
      len = $urandom_range(1, 6);
      for (int w = 0; w < len; w++) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0; in_data = 16'($urandom); in_last = 1'($urandom_range(0, 1));
          result_ready = 1'($urandom_range(0, 1));
          tick();
        end
        case ($urandom_range(0, 3))
          0:       d = '0;
          1:       d = 16'hFFFF;
          2:       d = 16'(1 << $urandom_range(0, 15));
          default: d = 16'($urandom);
        endcase
        send(d, w == len - 1);
      end
      drain_random();
    end

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
